// File: rtl/ss_inst_queue_pkg.sv
// ss_inst_queue_pkg: types and helpers shared by the instruction queue slice.
//  instruction_info_reg_t : packed decoded-instruction record (64 bits); a lane of
//                           out_data can be cast to it when WIDTH matches.
//  idx_width(depth)       : bits needed to index a storage array of 'depth' entries.
//  cnt_width(depth)       : bits needed to hold an occupancy of 0..depth.
package ss_inst_queue_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } instruction_info_reg_t;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ss_inst_queue_if.sv
// ss_inst_queue_if: decode/dispatch-side bundle of the superscalar instruction queue.
//  flush     : discard all contents at the next edge
//  in_valid  : push lanes (contiguous from lane 0), in_data lane i at [i*WIDTH +: WIDTH]
//  in_ready  : at least SS free slots
//  out_valid : lane i holds the (i+1)-th oldest entry, out_data likewise
//  pop_count : number of oldest entries consumed this cycle
//  count/empty/full : occupancy reporting
//  master = producer/consumer side, slave = the queue.
interface ss_inst_queue_if
   import ss_inst_queue_pkg::*;
#(
   parameter int unsigned SS    = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 64
) ();

   localparam int unsigned CW = $clog2(SS + 1);
   localparam int unsigned NW = cnt_width(DEPTH);

   logic                flush;
   logic [SS-1:0]       in_valid;
   logic [SS*WIDTH-1:0] in_data;
   logic                in_ready;
   logic [SS-1:0]       out_valid;
   logic [SS*WIDTH-1:0] out_data;
   logic [CW-1:0]       pop_count;
   logic [NW-1:0]       count;
   logic                empty;
   logic                full;

   modport master (
      output flush, in_valid, in_data, pop_count,
      input  in_ready, out_valid, out_data, count, empty, full
   );

   modport slave (
      input  flush, in_valid, in_data, pop_count,
      output in_ready, out_valid, out_data, count, empty, full
   );

endinterface

// File: rtl/ss_queue_mem.sv
// ss_queue_mem: DEPTH x WIDTH register array, SS write ports and SS combinational
// read ports. Storage is not reset.
//  clk   : clock
//  we    : per-lane write enable
//  waddr : lane i write index at [i*IW +: IW]
//  wdata : lane i write data at [i*WIDTH +: WIDTH]
//  raddr : lane i read index at [i*IW +: IW]
//  rdata : lane i read data at [i*WIDTH +: WIDTH]
module ss_queue_mem
   import ss_inst_queue_pkg::*;
#(
   parameter int unsigned SS    = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned IW   = idx_width(DEPTH)
) (
   input  logic                clk,
   input  logic [SS-1:0]       we,
   input  logic [SS*IW-1:0]    waddr,
   input  logic [SS*WIDTH-1:0] wdata,
   input  logic [SS*IW-1:0]    raddr,
   output logic [SS*WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write indices within one cycle are always distinct, so lane order is irrelevant.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SS; i++) begin
         if (we[i]) begin
            mem[waddr[i*IW +: IW]] <= wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < SS; i++) begin
         rdata[i*WIDTH +: WIDTH] = mem[raddr[i*IW +: IW]];
      end
   end

endmodule

// File: rtl/ss_inst_queue.sv
// ss_inst_queue: superscalar instruction queue between decode and rename/dispatch.
// Accepts 0..SS entries and releases 0..SS oldest entries per cycle, in order.
//  clk : clock, all state updates on posedge
//  rst : synchronous active-low reset (same effect as flush)
//  q   : queue bundle (slave side), see ss_inst_queue_if
module ss_inst_queue
   import ss_inst_queue_pkg::*;
#(
   parameter int unsigned SS    = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   ss_inst_queue_if.slave  q
);

   localparam int unsigned IW = idx_width(DEPTH);
   localparam int unsigned PW = IW + 1;  // extra wrap bit distinguishes full from empty

   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [PW-1:0]    count, avail, n_push, n_pop;
   logic             push_fire;
   logic [SS-1:0]    we;
   logic [SS*IW-1:0] waddr, raddr;
   logic             contig_ok, pop_ok, count_ok;

   always_comb begin
      count       = tail_q - head_q;
      avail       = (count > PW'(SS)) ? PW'(SS) : count;
      // A push needs room for a full group, judged before any same-cycle pop.
      q.in_ready  = (count <= PW'(DEPTH - SS));
      q.count     = count;
      q.empty     = (count == '0);
      q.full      = (count == PW'(DEPTH));
      push_fire   = q.in_ready && (|q.in_valid) && !q.flush;

      q.out_valid = '0;
      raddr       = '0;
      for (int i = 0; i < SS; i++) begin
         q.out_valid[i]      = (PW'(i) < count);
         raddr[i*IW +: IW]   = head_q[IW-1:0] + IW'(i);
      end

      // Set lanes are compacted in index order onto consecutive slots from tail.
      n_push = '0;
      we     = '0;
      waddr  = '0;
      for (int i = 0; i < SS; i++) begin
         if (q.in_valid[i]) begin
            we[i]             = push_fire;
            waddr[i*IW +: IW] = tail_q[IW-1:0] + n_push[IW-1:0];
            n_push            = n_push + 1'b1;
         end
      end

      // Over-long pops are clamped to what is actually presented.
      n_pop  = (PW'(q.pop_count) > avail) ? avail : PW'(q.pop_count);
      head_d = head_q + n_pop;
      tail_d = push_fire ? (tail_q + n_push) : tail_q;
      if (q.flush) begin
         head_d = '0;
         tail_d = '0;
      end

      contig_ok = ((q.in_valid & (q.in_valid + 1'b1)) == '0);
      pop_ok    = (PW'(q.pop_count) <= avail);
      count_ok  = (count <= PW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   ss_queue_mem #(
      .SS    (SS),
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (q.in_data),
      .raddr (raddr),
      .rdata (q.out_data)
   );

   a_in_valid_contig : assert property (@(posedge clk) disable iff (!rst) contig_ok);
   a_pop_in_range    : assert property (@(posedge clk) disable iff (!rst) pop_ok);
   a_count_in_range  : assert property (@(posedge clk) disable iff (!rst) count_ok);

endmodule

// File: tb/tb_ss_inst_queue.sv
// tb_ss_inst_queue: directed scenarios plus randomized traffic for ss_inst_queue,
// checked against a queue-based reference model.
module tb_ss_inst_queue;

   localparam int unsigned SS    = 2;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned WIDTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   ss_inst_queue_if #(.SS(SS), .DEPTH(DEPTH), .WIDTH(WIDTH)) qif ();

   ss_inst_queue #(.SS(SS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .q   (qif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mq [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour: a FIFO of entries, cleared by reset/flush, otherwise pop
   // then push (a group is taken whole only if SS slots were free before the pop).
   task automatic model_step(input logic r, input logic fl, input logic [1:0] v,
                             input logic [63:0] d0, input logic [63:0] d1, input int pc);
      int sz;
      int np;
      bit rdy;
      sz  = mq.size();
      rdy = (DEPTH - sz) >= SS;
      if (!r || fl) begin
         mq.delete();
      end else begin
         np = pc;
         if (np > sz) np = sz;
         repeat (np) void'(mq.pop_front());
         if (rdy) begin
            if (v[0]) mq.push_back(d0);
            if (v[1]) mq.push_back(d1);
         end
      end
   endtask

   task automatic check_state(input string tag);
      int sz;
      logic [1:0] ov;
      sz = mq.size();
      ov = {sz > 1, sz > 0};
      check_eq({tag, "_count"}, 64'(qif.count), 64'(sz));
      check_eq({tag, "_empty"}, 64'(qif.empty), 64'(sz == 0));
      check_eq({tag, "_full"}, 64'(qif.full), 64'(sz == DEPTH));
      check_eq({tag, "_in_ready"}, 64'(qif.in_ready), 64'((DEPTH - sz) >= SS));
      check_eq({tag, "_out_valid"}, 64'(qif.out_valid), 64'(ov));
      if (sz > 0) check_eq({tag, "_lane0"}, qif.out_data[63:0], mq[0]);
      if (sz > 1) check_eq({tag, "_lane1"}, qif.out_data[127:64], mq[1]);
   endtask

   task automatic cycle(input string tag, input logic [1:0] v, input logic [63:0] d0,
                        input logic [63:0] d1, input int pc, input logic fl);
      qif.in_valid  = v;
      qif.in_data   = {d1, d0};
      qif.pop_count = 2'(pc);
      qif.flush     = fl;
      @(posedge clk);
      model_step(rst, fl, v, d0, d1, pc);
      #1;
      check_state(tag);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [1:0] v;
      int         pc;
      logic       fl;
      int         sz;

      qif.flush     = 1'b0;
      qif.in_valid  = '0;
      qif.in_data   = '0;
      qif.pop_count = '0;

      // 1. reset then idle
      rst = 1'b0;
      cycle("rst", 2'b00, 64'h0, 64'h0, 0, 1'b0);
      cycle("rst", 2'b00, 64'h0, 64'h0, 0, 1'b0);
      rst = 1'b1;
      check_eq("rst_out_valid", 64'(qif.out_valid), 64'h0);
      check_eq("rst_empty", 64'(qif.empty), 64'h1);
      cycle("idle", 2'b00, 64'h0, 64'h0, 0, 1'b0);

      // 2. push then pop
      cycle("t2_push", 2'b11, 64'hA, 64'hB, 0, 1'b0);
      check_eq("t2_lane0_A", qif.out_data[63:0], 64'hA);
      check_eq("t2_lane1_B", qif.out_data[127:64], 64'hB);
      cycle("t2_pop1", 2'b00, 64'h0, 64'h0, 1, 1'b0);
      check_eq("t2_lane0_B", qif.out_data[63:0], 64'hB);
      check_eq("t2_ov01", 64'(qif.out_valid), 64'h1);
      cycle("t2_drain", 2'b00, 64'h0, 64'h0, 1, 1'b0);

      // 3. fill to full, held push, then drain
      for (int i = 0; i < 8; i++) cycle("t3_fill", 2'b11, rnd64(), rnd64(), 0, 1'b0);
      check_eq("t3_full", 64'(qif.full), 64'h1);
      check_eq("t3_in_ready", 64'(qif.in_ready), 64'h0);
      cycle("t3_held", 2'b11, 64'hCAFE_0001, 64'hCAFE_0002, 0, 1'b0);
      cycle("t3_pop_held", 2'b11, 64'hCAFE_0001, 64'hCAFE_0002, 2, 1'b0);
      check_eq("t3_count14", 64'(qif.count), 64'd14);
      cycle("t3_xy", 2'b11, 64'hCAFE_0001, 64'hCAFE_0002, 0, 1'b0);
      for (int i = 0; i < 8; i++) cycle("t3_drain", 2'b00, 64'h0, 64'h0, 2, 1'b0);
      check_eq("t3_empty", 64'(qif.empty), 64'h1);

      // 4. wrap-around at two per cycle
      cycle("t4_prime", 2'b11, rnd64(), rnd64(), 0, 1'b0);
      for (int i = 0; i < 20; i++) cycle("t4_stream", 2'b11, rnd64(), rnd64(), 2, 1'b0);
      check_eq("t4_count2", 64'(qif.count), 64'd2);
      cycle("t4_drain", 2'b00, 64'h0, 64'h0, 2, 1'b0);

      // 5. simultaneous push/pop, then flush beats push
      for (int i = 0; i < 3; i++) cycle("t5_fill", 2'b11, rnd64(), rnd64(), 0, 1'b0);
      cycle("t5_pushpop", 2'b11, rnd64(), rnd64(), 2, 1'b0);
      check_eq("t5_count6", 64'(qif.count), 64'd6);
      cycle("t5_flush", 2'b11, rnd64(), rnd64(), 0, 1'b1);
      check_eq("t5_count0", 64'(qif.count), 64'd0);
      check_eq("t5_empty", 64'(qif.empty), 64'h1);

      // 6. odd occupancy
      for (int i = 0; i < 15; i++) cycle("t6_single", 2'b01, rnd64(), 64'h0, 0, 1'b0);
      check_eq("t6_count15", 64'(qif.count), 64'd15);
      check_eq("t6_not_ready", 64'(qif.in_ready), 64'h0);
      cycle("t6_pop1", 2'b00, 64'h0, 64'h0, 1, 1'b0);
      check_eq("t6_ready", 64'(qif.in_ready), 64'h1);
      cycle("t6_flush", 2'b00, 64'h0, 64'h0, 0, 1'b1);

      // randomized traffic with occasional flush and mid-run reset
      for (int i = 0; i < 600; i++) begin
         sz = mq.size();
         case ($urandom_range(2, 0))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         pc  = $urandom_range((sz > 2) ? 2 : sz, 0);
         fl  = ($urandom_range(29, 0) == 0);
         rst = ($urandom_range(79, 0) != 0);
         cycle("rand", v, rnd64(), rnd64(), pc, fl);
      end
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
